// File: rtl/pov_vector_loader_pkg.sv
// Shared fixed-point formats, frame geometry and reset point-of-view for the POV loader.
// The overlay and the tracer import the same reset constants so all three agree.
package pov_vector_loader_pkg;

    localparam int QM         = 10;
    localparam int QN         = 12;
    localparam int QMN        = QM + QN;
    localparam int NVEC       = 6;
    localparam int FRAME_BITS = NVEC * QMN;
    localparam int CNT_W      = 8;

    localparam logic [CNT_W-1:0] CNT_FULL = 8'd132;
    localparam logic [CNT_W-1:0] CNT_SAT  = 8'd133;

    typedef logic [QMN-1:0] fx_t;

    // Field order matches wire order: first field is shifted in first (frame MSB).
    typedef struct packed {
        fx_t player_x;
        fx_t player_y;
        fx_t facing_x;
        fx_t facing_y;
        fx_t vplane_x;
        fx_t vplane_y;
    } pov_t;

    localparam pov_t POV_RESET = '{
        player_x: 22'd6144,
        player_y: 22'd6144,
        facing_x: 22'd4096,
        facing_y: 22'd0,
        vplane_x: 22'd0,
        vplane_y: 22'd2048
    };

    function automatic logic frame_complete(input logic [CNT_W-1:0] cnt, input logic ovf);
        return (cnt == CNT_FULL) && !ovf;
    endfunction

endpackage

// File: rtl/pov_vector_loader_spi_sync_edge.sv
// Three-stage synchronizer per SPI line with registered edge pulses.
// mosi and csb levels are delayed to stay aligned with the registered pulses.
module spi_sync_edge (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_csb,
    output logic o_sclk_rise,
    output logic o_csb_fall,
    output logic o_csb_rise,
    output logic o_mosi_sync,
    output logic o_csb_sync
);

    logic [2:0] r_sclk;
    logic [2:0] r_mosi;
    logic [2:0] r_csb;
    logic       r_sclk_rise;
    logic       r_csb_fall;
    logic       r_csb_rise;
    logic       r_mosi_sync;
    logic       r_csb_sync;

    // csb stages clear to 0 so a transfer already running at reset release makes no falling edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk      <= 3'b000;
            r_mosi      <= 3'b000;
            r_csb       <= 3'b000;
            r_sclk_rise <= 1'b0;
            r_csb_fall  <= 1'b0;
            r_csb_rise  <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_csb_sync  <= 1'b0;
        end else begin
            r_sclk      <= {r_sclk[1:0], i_sclk};
            r_mosi      <= {r_mosi[1:0], i_mosi};
            r_csb       <= {r_csb[1:0], i_csb};
            r_sclk_rise <= r_sclk[1] & ~r_sclk[2];
            r_csb_fall  <= ~r_csb[1] & r_csb[2];
            r_csb_rise  <= r_csb[1] & ~r_csb[2];
            r_mosi_sync <= r_mosi[1];
            r_csb_sync  <= r_csb[1];
        end
    end

    assign o_sclk_rise = r_sclk_rise;
    assign o_csb_fall  = r_csb_fall;
    assign o_csb_rise  = r_csb_rise;
    assign o_mosi_sync = r_mosi_sync;
    assign o_csb_sync  = r_csb_sync;

endmodule

// File: rtl/pov_vector_loader.sv
// SPI-loaded point-of-view vectors, double-buffered and applied to the live
// outputs only on the frame-end strobe so the vectors never change mid-frame.
module pov_vector_loader
    import pov_vector_loader_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_spi_sclk,
    input  logic           i_spi_mosi,
    input  logic           i_spi_csb,
    input  logic           i_frame_end,
    output logic [QMN-1:0] o_playerX,
    output logic [QMN-1:0] o_playerY,
    output logic [QMN-1:0] o_facingX,
    output logic [QMN-1:0] o_facingY,
    output logic [QMN-1:0] o_vplaneX,
    output logic [QMN-1:0] o_vplaneY,
    output logic           o_pov_pending
);

    logic                  w_sclk_rise;
    logic                  w_csb_fall;
    logic                  w_csb_rise;
    logic                  w_mosi_sync;
    logic                  w_csb_sync;
    logic                  w_accept;

    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_armed;
    pov_t                  r_staging;
    pov_t                  r_live;
    logic                  r_pending;

    spi_sync_edge u_sync (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_sclk      (i_spi_sclk),
        .i_mosi      (i_spi_mosi),
        .i_csb       (i_spi_csb),
        .o_sclk_rise (w_sclk_rise),
        .o_csb_fall  (w_csb_fall),
        .o_csb_rise  (w_csb_rise),
        .o_mosi_sync (w_mosi_sync),
        .o_csb_sync  (w_csb_sync)
    );

    // r_armed is only set by a csb falling edge seen after reset, so stale transfers are ignored.
    assign w_accept = w_csb_rise & r_armed & frame_complete(r_count, r_overflow);

    // Shift register, saturating bit counter, overflow flag and transfer arming.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else if (w_csb_fall) begin
            r_count    <= 8'd0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b1;
        end else if (w_csb_rise) begin
            r_armed    <= 1'b0;
        end else if (w_sclk_rise && !w_csb_sync && r_armed) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_sync};
            if (r_count != CNT_SAT) begin
                r_count <= r_count + 8'd1;
            end else begin
                r_count <= r_count;
            end
            if (r_count >= CNT_FULL) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end else begin
            r_armed <= r_armed;
        end
    end

    // Staging, pending flag and live outputs; live reads the old staging when accept and frame_end coincide.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_staging <= '0;
            r_live    <= POV_RESET;
            r_pending <= 1'b0;
        end else begin
            if (i_frame_end && r_pending) begin
                r_live <= r_staging;
            end else begin
                r_live <= r_live;
            end
            if (w_accept) begin
                r_staging <= pov_t'(r_shift);
                r_pending <= 1'b1;
            end else if (i_frame_end) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    assign o_playerX     = r_live.player_x;
    assign o_playerY     = r_live.player_y;
    assign o_facingX     = r_live.facing_x;
    assign o_facingY     = r_live.facing_y;
    assign o_vplaneX     = r_live.vplane_x;
    assign o_vplaneY     = r_live.vplane_y;
    assign o_pov_pending = r_pending;

endmodule

// File: tb/tb_pov_vector_loader.sv
// Directed and randomized bench for pov_vector_loader against a frame-level POV model.
module tb_pov_vector_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        mosi;
    logic        csb;
    logic        frame_end;
    logic [21:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic        pov_pending;

    logic [21:0] m_live[6];
    logic [21:0] m_stage[6];
    logic        m_pending;
    int          n_vec = 0;
    int          n_bad = 0;

    pov_vector_loader dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_spi_sclk    (sclk),
        .i_spi_mosi    (mosi),
        .i_spi_csb     (csb),
        .i_frame_end   (frame_end),
        .o_playerX     (playerX),
        .o_playerY     (playerY),
        .o_facingX     (facingX),
        .o_facingY     (facingY),
        .o_vplaneX     (vplaneX),
        .o_vplaneY     (vplaneY),
        .o_pov_pending (pov_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] fx(input real r);
        return 22'($rtoi(r * 4096.0));
    endfunction

    function automatic logic [131:0] pack6(input logic [21:0] a, b, c, d, e, f);
        return {a, b, c, d, e, f};
    endfunction

    function automatic logic [131:0] rand_frame();
        logic [131:0] fr;
        for (int k = 0; k < 6; k++) fr[131-22*k -: 22] = 22'($urandom);
        return fr;
    endfunction

    task automatic model_reset();
        m_live[0] = fx(1.5);  m_live[1] = fx(1.5);
        m_live[2] = fx(1.0);  m_live[3] = fx(0.0);
        m_live[4] = fx(0.0);  m_live[5] = fx(0.5);
        for (int k = 0; k < 6; k++) m_stage[k] = 22'd0;
        m_pending = 1'b0;
    endtask

    task automatic model_frame_end();
        if (m_pending) begin
            for (int k = 0; k < 6; k++) m_live[k] = m_stage[k];
        end
        m_pending = 1'b0;
    endtask

    task automatic model_accept(input logic [131:0] fr);
        for (int k = 0; k < 6; k++) m_stage[k] = fr[131-22*k -: 22];
        m_pending = 1'b1;
    endtask

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".playerX"}, playerX, m_live[0]);
        check({tag, ".playerY"}, playerY, m_live[1]);
        check({tag, ".facingX"}, facingX, m_live[2]);
        check({tag, ".facingY"}, facingY, m_live[3]);
        check({tag, ".vplaneX"}, vplaneX, m_live[4]);
        check({tag, ".vplaneY"}, vplaneY, m_live[5]);
        check({tag, ".pending"}, {21'd0, pov_pending}, {21'd0, m_pending});
    endtask

    task automatic pulse_frame_end();
        @(posedge clk); #1 frame_end = 1'b1;
        @(posedge clk); #1 frame_end = 1'b0;
        model_frame_end();
    endtask

    // Mode-0 SPI master at 4 clk per bit; rst_at >= 0 pulses reset before that bit.
    task automatic send_frame(input logic [131:0] fr, input int nbits, input int rst_at,
                              input bit fe_on_accept, input string tag);
        bit aborted = 1'b0;
        #($urandom_range(0, 39));
        csb = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(posedge clk); #1 reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                model_reset();
                aborted = 1'b1;
            end
            mosi = (i < 132) ? fr[131-i] : 1'($urandom);
            #20 sclk = 1'b1;
            #20 sclk = 1'b0;
        end
        #20;
        @(posedge clk); #1 csb = 1'b1; mosi = 1'b0;
        if (fe_on_accept) begin
            repeat (3) @(posedge clk);
            #1 frame_end = 1'b1;
            @(posedge clk); #1 frame_end = 1'b0;
            model_frame_end();
            if (nbits == 132 && !aborted) model_accept(fr);
        end else begin
            repeat (3) @(posedge clk);
            #1 check({tag, ".pending_early"}, {21'd0, pov_pending}, {21'd0, m_pending});
            @(posedge clk); #1;
            if (nbits == 132 && !aborted) model_accept(fr);
        end
        check_all(tag);
    endtask

    initial begin
        logic [131:0] fr;
        int nb;
        reset = 1'b1; sclk = 1'b0; mosi = 1'b0; csb = 1'b1; frame_end = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset POV holds across two frames without SPI traffic.
        check_all("reset");
        pulse_frame_end(); check_all("reset_fe1");
        pulse_frame_end(); check_all("reset_fe2");

        // Known vectors, staged then applied.
        fr = pack6(fx(3.25), fx(7.0), fx(0.0), fx(-1.0), fx(0.5), fx(0.0));
        send_frame(fr, 132, -1, 1'b0, "known_staged");
        pulse_frame_end(); check_all("known_applied");

        // Short and long frames are discarded.
        send_frame(rand_frame(), 131, -1, 1'b0, "short");
        send_frame(rand_frame(), 133, -1, 1'b0, "long");
        pulse_frame_end(); check_all("bad_fe");

        // Last accepted wins; accept aligned with frame_end.
        send_frame(rand_frame(), 132, -1, 1'b0, "frameA");
        send_frame(rand_frame(), 132, -1, 1'b0, "frameB");
        pulse_frame_end(); check_all("B_applied");
        send_frame(rand_frame(), 132, -1, 1'b1, "C_aligned");
        pulse_frame_end(); check_all("C_applied");

        // Reset mid-transfer, then a clean frame.
        send_frame(rand_frame(), 132, 60, 1'b0, "reset_mid");
        send_frame(rand_frame(), 132, -1, 1'b0, "after_reset");
        pulse_frame_end(); check_all("after_reset_fe");

        // Random data, random phase, occasional bad lengths and aligned strobes.
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 7))
                0:       nb = 131;
                1:       nb = 133;
                default: nb = 132;
            endcase
            send_frame(rand_frame(), nb, -1, ($urandom_range(0, 9) == 0), "rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_frame_end(); check_all("rand_fe");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
